mario_vertical_motion: RTL and testbench
========================================

Name: mario_vertical_motion

Overview:
Sequential vertical-physics engine for Mario: owns Mario_Y_Pos and Mario_Y_Motion and advances them once per frame tick. It consumes the is_in_air/level verdict that the ground/platform detector computes from these same two outputs, closing the loop. Sits between the keyboard decode (jump key) and the sprite/collision logic. It handles the jump, gravity, landing snap and ceiling clamp.

Parameters:
Y_START, 13'd384, Mario_Y_Pos after reset (ground line).
JUMP_VEL, 12, initial upward speed in pixels/frame; applied as -JUMP_VEL.
GRAVITY, 1, speed increment per gravity step.
GRAVITY_DIV, 1, frames per gravity step (>=1).
MAX_FALL, 8, terminal downward speed in pixels/frame.
Y_MIN, 13'd0, top-of-screen clamp for Mario_Y_Pos.

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-low reset
frame_clk  input  1  vsync-rate frame strobe, asynchronous-phase level signal
jump_key  input  1  jump button level, 1 = pressed
is_in_air  input  1  from ground detector, evaluated on current outputs
level  input  13  landing Y from ground detector
Mario_Y_Pos  output  13  unsigned Y position (feet reference)
Mario_Y_Motion  output  13  two's-complement Y speed, negative = up
airborne  output  1  1 when state != GROUND
jump_pulse  output  1  one-Clk pulse on the cycle a jump starts

Behaviour:
- All state updates only on Clk rising edge. Reset is sampled synchronously; Reset=0 takes priority over everything.
- Reset values: Mario_Y_Pos=Y_START, Mario_Y_Motion=0, state=GROUND, gravity counter=0, jump_armed=1, airborne=0, jump_pulse=0, frame_clk edge register=0.
- Tick: frame_clk is registered twice. tick=1 for exactly one Clk cycle on a detected 0->1 edge. All motion updates happen only in the tick cycle; outputs hold otherwise.
- Sampling: is_in_air and level are sampled in the tick cycle. The detector sees Y_Pos+Y_Motion modulo 2^13, so negative motion wraps correctly.
- Arithmetic: new position is computed 14-bit signed as {0,Y_Pos} + sext(Y_Motion). Motion is held internally signed and saturated to MAX_FALL downward.
- Gravity step: the counter increments per tick while airborne. When it reaches GRAVITY_DIV-1, Motion += GRAVITY and the counter clears. The counter clears on entering GROUND.
- jump_armed: set at any tick where jump_key=0, cleared when a jump starts. A held key never re-jumps.
- GROUND, evaluated at tick in this priority:
  (1) jump_key=1 and jump_armed -> Motion=-JUMP_VEL, Pos unchanged, jump_pulse=1, go to RISE.
  (2) is_in_air=1 (walked off an edge) -> Motion=+GRAVITY, go to FALL.
  (3) otherwise Pos=level, Motion=0.
- RISE, at tick:
  - Pos += Motion, then apply a gravity step.
  - If the new Pos < Y_MIN: Pos=Y_MIN, Motion=0, go to FALL.
  - If Motion after the step >= 0: go to FALL.
  - is_in_air is ignored in RISE, so rising through a platform band never lands.
- FALL, at tick:
  - is_in_air=0 -> Pos=level, Motion=0, go to GROUND (landing snap).
  - Else Pos += Motion, apply a gravity step, Motion=min(Motion, MAX_FALL).
- Jump requests outside GROUND are ignored, but still affect jump_armed.
- airborne is registered: it equals (state != GROUND) and is updated in the same cycle as the state.
- Latency: a frame_clk rising edge changes the outputs 3 Clk cycles later. There is no other latency.
- Reset mid-jump returns all outputs to their reset values on the next Clk edge, regardless of tick.

Test Plan:
- Reset=0 for 2 cycles, is_in_air=0, level=384 -> Mario_Y_Pos=384, Mario_Y_Motion=0, airborne=0, jump_pulse=0.
- Defaults, jump_key=1 then tick -> jump_pulse for 1 cycle, Motion=13'h1FF4 (-12), Pos=384. On following ticks Pos runs 372, 361 … down to 306 and Motion rises to 0, which enters FALL. When the bench returns is_in_air=0 with level=384, the next tick gives Pos=384, Motion=0, airborne=0.
- Hold jump_key=1 through the landing and 3 more ticks -> no second jump_pulse. Release for one tick, press again -> jump starts.
- In GROUND, drive is_in_air=1 -> next tick gives FALL with Motion=1. Motion then climbs 2, 3 … and saturates at 8. Driving is_in_air=0 with level=256 snaps Pos=256, Motion=0.
- With JUMP_VEL=40 and Y_MIN=0 -> Pos clamps at 0, Motion=0, state=FALL. During RISE, is_in_air=0 with level=256 is ignored.
- Assert Reset=0 in mid-RISE between ticks -> the next edge gives Pos=384, Motion=0, airborne=0. A frame_clk held high with no new edge produces no further updates.

Source files
------------

// File: rtl/mario_vertical_motion.sv
// rtl/mario_vertical_motion.sv - frame-ticked vertical physics for Mario (jump, gravity, landing, ceiling)
module mario_vertical_motion #(
    parameter logic [12:0] Y_START     = 13'd384,
    parameter int          JUMP_VEL    = 12,
    parameter int          GRAVITY     = 1,
    parameter int          GRAVITY_DIV = 1,
    parameter int          MAX_FALL    = 8,
    parameter logic [12:0] Y_MIN       = 13'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        jump_key,
    input  logic        is_in_air,
    input  logic [12:0] level,
    output logic [12:0] Mario_Y_Pos,
    output logic [12:0] Mario_Y_Motion,
    output logic        airborne,
    output logic        jump_pulse
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    // Motion constants held as 13-bit two's complement so they add directly to the speed register.
    localparam logic signed [12:0] JUMP_MOT  = 13'(-JUMP_VEL);
    localparam logic signed [12:0] GRAV_MOT  = 13'(GRAVITY);
    localparam logic signed [12:0] MAXF_MOT  = 13'(MAX_FALL);
    localparam logic        [7:0]  GDIV_LAST = 8'(GRAVITY_DIV - 1);
    localparam logic signed [13:0] Y_MIN_S   = {1'b0, Y_MIN};

    // frame_clk is asynchronous to Clk: two synchroniser flops, then an edge-history flop.
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        edge_q,  edge_d;

    state_t             state_q, state_d;
    logic        [12:0] pos_q, pos_d;
    logic signed [12:0] mot_q, mot_d;
    logic        [7:0]  grav_cnt_q, grav_cnt_d;
    logic               jump_armed_q, jump_armed_d;
    logic               airborne_q, airborne_d;
    logic               jump_pulse_q, jump_pulse_d;

    logic               tick;
    logic signed [13:0] pos_step;
    logic               grav_hit;
    logic signed [12:0] mot_grav;
    logic        [7:0]  cnt_grav;

    // Next-state physics: everything moves only in the single tick cycle after a frame edge.
    always_comb begin
        sync1_d      = frame_clk;
        sync2_d      = sync1_q;
        edge_d       = sync2_q;
        tick         = sync2_q & ~edge_q;

        state_d      = state_q;
        pos_d        = pos_q;
        mot_d        = mot_q;
        grav_cnt_d   = grav_cnt_q;
        jump_armed_d = jump_armed_q;
        jump_pulse_d = 1'b0;

        // Position is widened to 14-bit signed so an upward move past row 0 shows as negative.
        pos_step = $signed({1'b0, pos_q}) + $signed({mot_q[12], mot_q});
        grav_hit = (grav_cnt_q == GDIV_LAST);
        mot_grav = grav_hit ? (mot_q + GRAV_MOT) : mot_q;
        cnt_grav = grav_hit ? 8'd0 : (grav_cnt_q + 8'd1);

        if (tick) begin
            if (!jump_key) begin
                jump_armed_d = 1'b1;
            end
            case (state_q)
                GROUND: begin
                    grav_cnt_d = 8'd0;
                    if (jump_key && jump_armed_q) begin
                        mot_d        = JUMP_MOT;
                        jump_pulse_d = 1'b1;
                        jump_armed_d = 1'b0;
                        state_d      = RISE;
                    end else if (is_in_air) begin
                        mot_d   = GRAV_MOT;
                        state_d = FALL;
                    end else begin
                        pos_d = level;
                        mot_d = 13'sd0;
                    end
                end
                RISE: begin
                    // Ground verdict is ignored while rising so platforms are passed through from below.
                    pos_d      = pos_step[12:0];
                    mot_d      = mot_grav;
                    grav_cnt_d = cnt_grav;
                    if (pos_step < Y_MIN_S) begin
                        pos_d   = Y_MIN;
                        mot_d   = 13'sd0;
                        state_d = FALL;
                    end else if (!mot_grav[12]) begin
                        state_d = FALL;
                    end
                end
                FALL: begin
                    if (!is_in_air) begin
                        pos_d      = level;
                        mot_d      = 13'sd0;
                        grav_cnt_d = 8'd0;
                        state_d    = GROUND;
                    end else begin
                        pos_d      = pos_step[12:0];
                        grav_cnt_d = cnt_grav;
                        mot_d      = (mot_grav > MAXF_MOT) ? MAXF_MOT : mot_grav;
                    end
                end
                default: begin
                    state_d    = GROUND;
                    grav_cnt_d = 8'd0;
                end
            endcase
        end

        airborne_d = (state_d != GROUND);
    end

    // Single register bank for the FSM, physics state and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            edge_q       <= 1'b0;
            state_q      <= GROUND;
            pos_q        <= Y_START;
            mot_q        <= 13'sd0;
            grav_cnt_q   <= 8'd0;
            jump_armed_q <= 1'b1;
            airborne_q   <= 1'b0;
            jump_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            edge_q       <= edge_d;
            state_q      <= state_d;
            pos_q        <= pos_d;
            mot_q        <= mot_d;
            grav_cnt_q   <= grav_cnt_d;
            jump_armed_q <= jump_armed_d;
            airborne_q   <= airborne_d;
            jump_pulse_q <= jump_pulse_d;
        end
    end

    assign Mario_Y_Pos    = pos_q;
    assign Mario_Y_Motion = mot_q;
    assign airborne       = airborne_q;
    assign jump_pulse     = jump_pulse_q;

endmodule

// File: tb/tb_mario_vertical_motion.sv
// tb/tb_mario_vertical_motion.sv - directed self-checking bench for mario_vertical_motion
module tb_mario_vertical_motion;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_clk;
    logic        jk1, air1, jk2, air2;
    logic [12:0] lvl1, lvl2;
    logic [12:0] pos1, mot1, pos2, mot2;
    logic        airb1, jp1, airb2, jp2;

    logic [12:0] r_pos1, r_mot1, r_pos2, r_mot2;
    logic        r_airb1, r_jp1, r_airb2, r_jp2, r_jp1_after, r_jp2_after;

    int checks = 0;
    int errors = 0;

    int rise_pos [12] = '{372, 361, 351, 342, 334, 327, 321, 316, 312, 309, 307, 306};
    int fall_pos [9]  = '{385, 387, 390, 394, 399, 405, 412, 420, 428};
    int fall_mot [9]  = '{2, 3, 4, 5, 6, 7, 8, 8, 8};
    int big_pos  [10] = '{344, 305, 267, 230, 194, 159, 125, 92, 60, 29};

    always #5 clk = ~clk;

    mario_vertical_motion dut1 (
        .Clk            (clk),
        .Reset          (resetn),
        .frame_clk      (frame_clk),
        .jump_key       (jk1),
        .is_in_air      (air1),
        .level          (lvl1),
        .Mario_Y_Pos    (pos1),
        .Mario_Y_Motion (mot1),
        .airborne       (airb1),
        .jump_pulse     (jp1)
    );

    mario_vertical_motion #(.JUMP_VEL(40), .Y_MIN(13'd0)) dut2 (
        .Clk            (clk),
        .Reset          (resetn),
        .frame_clk      (frame_clk),
        .jump_key       (jk2),
        .is_in_air      (air2),
        .level          (lvl2),
        .Mario_Y_Pos    (pos2),
        .Mario_Y_Motion (mot2),
        .airborne       (airb2),
        .jump_pulse     (jp2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: raise frame_clk, capture outputs 3 edges later, capture pulse one edge after that.
    task automatic frame_tick();
        frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        r_pos1 = pos1; r_mot1 = mot1; r_airb1 = airb1; r_jp1 = jp1;
        r_pos2 = pos2; r_mot2 = mot2; r_airb2 = airb2; r_jp2 = jp2;
        frame_clk = 1'b0;
        @(posedge clk);
        #1;
        r_jp1_after = jp1;
        r_jp2_after = jp2;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; frame_clk = 1'b0;
        jk1 = 1'b0; air1 = 1'b0; lvl1 = 13'd384;
        jk2 = 1'b0; air2 = 1'b0; lvl2 = 13'd384;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pos", 32'(pos1), 384);
        check("rst_mot", 32'(mot1), 0);
        check("rst_airb", 32'(airb1), 0);
        check("rst_jp", 32'(jp1), 0);
        check("rst_pos2", 32'(pos2), 384);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Jump from ground; detector claims air throughout the rise, which must be ignored.
        jk1 = 1'b1; air1 = 1'b1;
        frame_tick();
        check("jump_pulse", 32'(r_jp1), 1);
        check("jump_pulse_off", 32'(r_jp1_after), 0);
        check("jump_mot", 32'(r_mot1), 32'h1FF4);
        check("jump_pos", 32'(r_pos1), 384);
        check("jump_airb", 32'(r_airb1), 1);
        for (int i = 0; i < 12; i++) begin
            frame_tick();
            check($sformatf("rise_pos%0d", i), 32'(r_pos1), 32'(rise_pos[i]));
            check($sformatf("rise_mot%0d", i), 32'(r_mot1), 32'((i - 11) & 'h1FFF));
            check($sformatf("rise_airb%0d", i), 32'(r_airb1), 1);
        end
        air1 = 1'b0; lvl1 = 13'd384;
        frame_tick();
        check("land_pos", 32'(r_pos1), 384);
        check("land_mot", 32'(r_mot1), 0);
        check("land_airb", 32'(r_airb1), 0);
        check("land_jp", 32'(r_jp1), 0);

        // Held key must not re-jump; release then press re-arms.
        for (int i = 0; i < 3; i++) begin
            frame_tick();
            check($sformatf("held_jp%0d", i), 32'(r_jp1), 0);
            check($sformatf("held_pos%0d", i), 32'(r_pos1), 384);
        end
        jk1 = 1'b0;
        frame_tick();
        check("release_jp", 32'(r_jp1), 0);
        jk1 = 1'b1;
        frame_tick();
        check("rejump_jp", 32'(r_jp1), 1);
        check("rejump_mot", 32'(r_mot1), 32'h1FF4);

        // Mid-rise synchronous reset between ticks.
        frame_tick();
        check("midrise_pos", 32'(r_pos1), 372);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_pos", 32'(pos1), 384);
        check("midrst_mot", 32'(mot1), 0);
        check("midrst_airb", 32'(airb1), 0);
        resetn = 1'b1; jk1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Walk off an edge; frame_clk held high must give exactly one update.
        air1 = 1'b1; lvl1 = 13'd384;
        frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("walk_mot", 32'(mot1), 1);
        check("walk_pos", 32'(pos1), 384);
        check("walk_airb", 32'(airb1), 1);
        repeat (8) @(posedge clk);
        #1;
        check("hold_mot", 32'(mot1), 1);
        check("hold_pos", 32'(pos1), 384);
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            frame_tick();
            check($sformatf("fall_pos%0d", i), 32'(r_pos1), 32'(fall_pos[i]));
            check($sformatf("fall_mot%0d", i), 32'(r_mot1), 32'(fall_mot[i]));
        end
        air1 = 1'b0; lvl1 = 13'd256;
        frame_tick();
        check("snap_pos", 32'(r_pos1), 256);
        check("snap_mot", 32'(r_mot1), 0);
        check("snap_airb", 32'(r_airb1), 0);

        // Big jump into the top-of-screen clamp; ground verdict at 256 ignored while rising.
        jk2 = 1'b1; air2 = 1'b0; lvl2 = 13'd256;
        frame_tick();
        check("big_jp", 32'(r_jp2), 1);
        check("big_mot", 32'(r_mot2), 32'h1FD8);
        check("big_pos", 32'(r_pos2), 384);
        for (int i = 0; i < 10; i++) begin
            frame_tick();
            check($sformatf("big_pos%0d", i), 32'(r_pos2), 32'(big_pos[i]));
            check($sformatf("big_mot%0d", i), 32'(r_mot2), 32'((i - 39) & 'h1FFF));
        end
        frame_tick();
        check("clamp_pos", 32'(r_pos2), 0);
        check("clamp_mot", 32'(r_mot2), 0);
        check("clamp_airb", 32'(r_airb2), 1);
        frame_tick();
        check("big_land_pos", 32'(r_pos2), 256);
        check("big_land_airb", 32'(r_airb2), 0);
        check("big_land_jp", 32'(r_jp2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
